// File: rtl/switch_reader.sv
// Board switch reader: 2-flop sync, tick-sampled 3-deep debounce,
// change flags with clear-on-read and a registered change interrupt.
module switch_reader #(
    parameter int unsigned DB_CYCLES = 1000
) (
    input  logic        led_clk,
    input  logic        ledrst,
    input  logic        switchcs,
    input  logic        switchread,
    input  logic [1:0]  switchaddr,
    input  logic [23:0] switch_i,
    output logic [15:0] switchrdata,
    output logic        switch_irq
);

    localparam logic [15:0] LP_LAST = 16'(DB_CYCLES - 1);

    logic [23:0] r_sync1;
    logic [23:0] r_sync2;
    logic [15:0] r_presc;
    logic        r_tick_d;
    logic [23:0] r_h0;
    logic [23:0] r_h1;
    logic [23:0] r_h2;
    logic [23:0] r_stable;
    logic [23:0] r_chg;
    logic        r_irq;

    logic        w_tick;
    logic        w_rd;
    logic [23:0] w_all1;
    logic [23:0] w_all0;
    logic [23:0] w_stable_nxt;
    logic [23:0] w_set;
    logic [23:0] w_clr;

    assign w_tick = (r_presc == LP_LAST);
    assign w_rd   = switchcs & switchread;

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= switch_i;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            r_presc  <= '0;
            r_tick_d <= 1'b0;
        end else begin
            r_presc  <= w_tick ? 16'd0 : r_presc + 16'd1;
            r_tick_d <= w_tick;
        end
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            r_h0 <= '0;
            r_h1 <= '0;
            r_h2 <= '0;
        end else if (w_tick) begin
            r_h0 <= r_sync2;
            r_h1 <= r_h0;
            r_h2 <= r_h1;
        end
    end

    // A bit only moves when all three samples agree; unanimity already implies
    // "differs from stable" whenever the update actually changes the bit.
    assign w_all1 = r_h0 & r_h1 & r_h2;
    assign w_all0 = ~(r_h0 | r_h1 | r_h2);

    always_comb begin
        w_stable_nxt = r_stable;
        if (r_tick_d) begin
            w_stable_nxt = (r_stable | w_all1) & ~w_all0;
        end
    end

    assign w_set = r_stable ^ w_stable_nxt;

    // Only the bits actually returned this cycle are cleared.
    always_comb begin
        w_clr = '0;
        if (w_rd && switchaddr[0]) begin
            if (switchaddr[1]) begin
                w_clr[23:16] = r_chg[23:16];
            end else begin
                w_clr[15:0] = r_chg[15:0];
            end
        end
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            r_stable <= '0;
            r_chg    <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_stable <= w_stable_nxt;
            r_chg    <= (r_chg & ~w_clr) | w_set;
            r_irq    <= |r_chg;
        end
    end

    always_comb begin
        switchrdata = 16'h0000;
        if (w_rd) begin
            case (switchaddr)
                2'b00:   switchrdata = r_stable[15:0];
                2'b10:   switchrdata = {8'h00, r_stable[23:16]};
                2'b01:   switchrdata = r_chg[15:0];
                default: switchrdata = {8'h00, r_chg[23:16]};
            endcase
        end
    end

    assign switch_irq = r_irq;

endmodule

// File: tb/tb_switch_reader.sv
// Directed bench for switch_reader with DB_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_switch_reader;

    logic        led_clk;
    logic        ledrst;
    logic        switchcs;
    logic        switchread;
    logic [1:0]  switchaddr;
    logic [23:0] switch_i;
    logic [15:0] switchrdata;
    logic        switch_irq;

    int n_chk;
    int n_pass;
    int cyc;

    switch_reader #(.DB_CYCLES(4)) dut (
        .led_clk     (led_clk),
        .ledrst      (ledrst),
        .switchcs    (switchcs),
        .switchread  (switchread),
        .switchaddr  (switchaddr),
        .switch_i    (switch_i),
        .switchrdata (switchrdata),
        .switch_irq  (switch_irq)
    );

    initial led_clk = 1'b0;
    always #5 led_clk = ~led_clk;

    // Rising edges since reset release; capture ticks land on cyc%4==0.
    always @(posedge led_clk or posedge ledrst) begin
        if (ledrst) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        switchcs   = 1'b1;
        switchread = 1'b1;
        switchaddr = a;
        #1 d = switchrdata;
        @(negedge led_clk);
        switchcs   = 1'b0;
        switchread = 1'b0;
        switchaddr = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int k;
        int c0;
        int pt;
        int t;
        int guard;
        logic irq_seen;

        n_chk = 0;
        n_pass = 0;
        switch_i = '0;
        switchcs = 1'b0;
        switchread = 1'b0;
        switchaddr = 2'b00;
        ledrst = 1'b1;
        repeat (3) @(negedge led_clk);
        ledrst = 1'b0;

        #1 check("idle_zero", 32'(switchrdata), 32'h0);
        @(negedge led_clk);
        rd(2'b00, d); check("rst_off00", 32'(d), 32'h0);
        rd(2'b01, d); check("rst_off01", 32'(d), 32'h0);
        check("rst_irq", 32'(switch_irq), 32'h0);

        // Rising edge latency and irq lag, observed through a held offset-00 read.
        switch_i   = 24'hA50001;
        switchcs   = 1'b1;
        switchread = 1'b1;
        switchaddr = 2'b00;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge led_clk);
            if (k == 0 && switchrdata != 16'h0) begin
                k = c;
                check("irq_lag0", 32'(switch_irq), 32'h0);
            end else if (k != 0 && c == k + 1) begin
                check("irq_lag1", 32'(switch_irq), 32'h1);
            end
        end
        check("lat_range", 32'(k >= 11 && k <= 15), 32'h1);
        switchcs = 1'b0;
        switchread = 1'b0;
        rd(2'b00, d); check("stable_lo", 32'(d), 32'h0001);
        rd(2'b10, d); check("stable_hi", 32'(d), 32'h00A5);
        check("irq_on", 32'(switch_irq), 32'h1);

        switchcs = 1'b1;
        switchread = 1'b0;
        #1 check("no_rd_zero", 32'(switchrdata), 32'h0);
        switchcs = 1'b0;
        switchread = 1'b1;
        #1 check("no_cs_zero", 32'(switchrdata), 32'h0);
        switchread = 1'b0;

        rd(2'b01, d); check("chg_lo", 32'(d), 32'h0001);
        rd(2'b01, d); check("chg_lo_clr", 32'(d), 32'h0000);
        check("irq_hi_pend", 32'(switch_irq), 32'h1);
        rd(2'b11, d); check("chg_hi", 32'(d), 32'h00A5);
        check("irq_lag_clr", 32'(switch_irq), 32'h1);
        @(negedge led_clk);
        check("irq_off", 32'(switch_irq), 32'h0);
        rd(2'b11, d); check("chg_hi_clr", 32'(d), 32'h0000);

        // 5-cycle glitch spans at most two ticks.
        switch_i[3] = 1'b1;
        irq_seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (c == 5) switch_i[3] = 1'b0;
            @(negedge led_clk);
            if (switch_irq) irq_seen = 1'b1;
        end
        check("glitch_irq", 32'(irq_seen), 32'h0);
        rd(2'b00, d); check("glitch_stable", 32'(d), 32'h0001);
        rd(2'b01, d); check("glitch_chg", 32'(d), 32'h0000);

        // Leave chg[2] set from a rise and a fall, then read on the next rise edge.
        switch_i[2] = 1'b1;
        repeat (20) @(negedge led_clk);
        switch_i[2] = 1'b0;
        repeat (20) @(negedge led_clk);
        c0 = cyc;
        switch_i[2] = 1'b1;
        pt = c0 + 3;
        while (pt % 4 != 0) pt++;
        t = pt + 9;
        guard = 0;
        while (cyc != t - 2 && guard < 100) begin
            @(negedge led_clk);
            guard++;
        end
        check("align_guard", 32'(guard < 100), 32'h1);
        switchcs = 1'b1;
        switchread = 1'b1;
        switchaddr = 2'b00;
        #1 check("pre_rise", 32'(switchrdata), 32'h0001);
        @(negedge led_clk);
        switchaddr = 2'b01;
        #1 check("rise_rd", 32'(switchrdata), 32'h0004);
        @(negedge led_clk);
        switchcs = 1'b0;
        switchread = 1'b0;
        switchaddr = 2'b00;
        rd(2'b00, d); check("post_rise", 32'(d), 32'h0005);
        rd(2'b01, d); check("set_wins", 32'(d), 32'h0004);
        rd(2'b01, d); check("set_wins_clr", 32'(d), 32'h0000);

        // Reset in the middle of a debounce.
        switch_i = 24'h000010;
        repeat (6) @(negedge led_clk);
        ledrst = 1'b1;
        switchcs = 1'b1;
        switchread = 1'b1;
        switchaddr = 2'b00;
        #1 check("rst_mid_stable", 32'(switchrdata), 32'h0);
        check("rst_mid_irq", 32'(switch_irq), 32'h0);
        switchaddr = 2'b01;
        #1 check("rst_mid_chg", 32'(switchrdata), 32'h0);
        @(negedge led_clk);
        ledrst = 1'b0;
        switchaddr = 2'b00;
        k = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge led_clk);
            if (k == 0 && switchrdata == 16'h0010) k = c;
        end
        check("rst_relat", 32'(k >= 11 && k <= 15), 32'h1);
        switchcs = 1'b0;
        switchread = 1'b0;
        rd(2'b10, d); check("rst_hi", 32'(d), 32'h0000);
        check("rst_irq_on", 32'(switch_irq), 32'h1);
        rd(2'b01, d); check("rst_chg", 32'(d), 32'h0010);
        rd(2'b01, d); check("rst_chg_clr", 32'(d), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
